button_debounce_toggle: RTL and testbench



---
 rtl/button_debounce_toggle.sv | 128 ++++++++++++
 tb/tb_button_debounce_toggle.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_toggle.sv
// button_debounce_toggle
// Synchronizes a raw, bouncy push-button pin, debounces it with a
// counter-qualified four-state FSM and produces a clean level, one-cycle
// press/release strobes and an LED toggle register. Every output is a flop.

module button_debounce_toggle #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic BUTTON,
  output logic BTN_LEVEL,
  output logic BTN_PRESS,
  output logic BTN_RELEASE,
  output logic LED_TOGGLE
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  // Last counter value before a level change is accepted.
  localparam logic [CNT_WIDTH-1:0] cnt_last = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Pressed-is-1 view of the pin, before synchronization.
  logic b_raw;
  assign b_raw = BUTTON ^ ACTIVE_LOW;

  logic                 sync_q1;
  logic                 sync_q2;
  state_t               state_q;
  state_t               state_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 level_d;
  logic                 press_d;
  logic                 release_d;
  logic                 toggle_d;

  // Two-flop synchronizer; only sync_q2 is seen by the FSM.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, which is what makes the two stages a chain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= b_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Next state, counter and registered-output values.
  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RELEASED: begin
        if (sync_q2) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync_q2) begin
          state_d = RELEASED;
        end else if (cnt_q == cnt_last) begin
          state_d = PRESSED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!sync_q2) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync_q2) begin
          state_d = PRESSED;
        end else if (cnt_q == cnt_last) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase

    // Outputs are computed from the transition and registered with it, so
    // they change on the same edge the FSM enters the new state.
    level_d   = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    press_d   = (state_q == PRESS_WAIT) && (state_d == PRESSED);
    release_d = (state_q == RELEASE_WAIT) && (state_d == RELEASED);
    toggle_d  = LED_TOGGLE ^ press_d;
  end

  // FSM state, debounce counter and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= RELEASED;
      cnt_q       <= '0;
      BTN_LEVEL   <= 1'b0;
      BTN_PRESS   <= 1'b0;
      BTN_RELEASE <= 1'b0;
      LED_TOGGLE  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      BTN_LEVEL   <= level_d;
      BTN_PRESS   <= press_d;
      BTN_RELEASE <= release_d;
      LED_TOGGLE  <= toggle_d;
    end
  end

endmodule

// File: tb/tb_button_debounce_toggle.sv
// tb_button_debounce_toggle
// Drives an active-high and an active-low instance (DEBOUNCE_CYCLES=4) with
// the same logical button and compares both against a table of expected
// outputs, hand-written corner sequences and a run-length reference model.

module tb_button_debounce_toggle;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst;
  logic button;
  logic button_al;

  logic lvl0, prs0, rel0, tog0;
  logic lvl1, prs1, rel1, tog1;
  logic [3:0] pack0;
  logic [3:0] pack1;
  assign pack0 = {lvl0, prs0, rel0, tog0};
  assign pack1 = {lvl1, prs1, rel1, tog1};

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  button_debounce_toggle #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_WIDTH      (16),
    .ACTIVE_LOW     (1'b0)
  ) dut_ah (
    .CLK        (clk),
    .RST        (rst),
    .BUTTON     (button),
    .BTN_LEVEL  (lvl0),
    .BTN_PRESS  (prs0),
    .BTN_RELEASE(rel0),
    .LED_TOGGLE (tog0)
  );

  button_debounce_toggle #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_WIDTH      (3),
    .ACTIVE_LOW     (1'b1)
  ) dut_al (
    .CLK        (clk),
    .RST        (rst),
    .BUTTON     (button_al),
    .BTN_LEVEL  (lvl1),
    .BTN_PRESS  (prs1),
    .BTN_RELEASE(rel1),
    .LED_TOGGLE (tog1)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: a level change is accepted once the synchronized
  // button (the pin value from two edges earlier) has disagreed with the
  // debounced level on DEB+1 consecutive edges.
  logic m_h1, m_h2, m_level, m_press, m_rel, m_tog;
  int   m_run;
  logic [3:0] m_pack;
  assign m_pack = {m_level, m_press, m_rel, m_tog};

  task automatic model_reset();
    m_h1 = 0; m_h2 = 0; m_level = 0; m_press = 0; m_rel = 0; m_tog = 0;
    m_run = 0;
  endtask

  task automatic model_edge(input logic bv);
    logic sp;
    sp = m_h2;
    m_h2 = m_h1;
    m_h1 = bv;
    m_press = 0;
    m_rel = 0;
    if (sp != m_level) begin
      m_run++;
      if (m_run == DEB + 1) begin
        m_level = sp;
        m_press = sp;
        m_rel   = !sp;
        m_tog   = m_tog ^ sp;
        m_run   = 0;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (step %0d)", name, act, exp, step_no);
    end
  endtask

  // One clock: drive at the negedge, let the edge happen, compare at the next negedge.
  task automatic step(input logic bv);
    button    = bv;
    button_al = ~bv;
    @(posedge clk);
    model_edge(bv);
    @(negedge clk);
    step_no++;
    check("model_ah", pack0, m_pack);
    check("model_al", pack1, m_pack);
  endtask

  task automatic run_seg(input int n, input logic bv, output int np, output int nr,
                         output int pp, output int rp);
    np = 0; nr = 0; pp = -1; rp = -1;
    for (int i = 0; i < n; i++) begin
      step(bv);
      if (prs0) begin np++; if (pp < 0) pp = i; end
      if (rel0) begin nr++; if (rp < 0) rp = i; end
    end
  endtask

  // Asserts reset between clock edges, checks outputs cleared without an
  // edge, holds it over two edges and releases it at a negedge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_rst_ah"}, pack0, 4'b0000);
    check({tag, "_rst_al"}, pack1, 4'b0000);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       bin;
    logic [3:0] exp;   // {level, press, release, toggle}
  } vec_t;
  vec_t vecs[$];

  task automatic add(input int n, input logic b, input logic [3:0] e);
    repeat (n) vecs.push_back('{bin: b, exp: e});
  endtask

  initial begin
    int np, nr, pp, rp, tp, tr;
    int last_press;
    logic bv;
    int len;

    // Bounce pattern that never qualifies.
    add(3, 1'b1, 4'b0000); add(1, 1'b0, 4'b0000); add(2, 1'b1, 4'b0000);
    add(5, 1'b0, 4'b0000);
    // Clean press: accepted on the 7th edge after the pin rises.
    add(6, 1'b1, 4'b0000); add(1, 1'b1, 4'b1101); add(3, 1'b1, 4'b1001);
    // Clean release: symmetric latency, toggle untouched.
    add(6, 1'b0, 4'b1001); add(1, 1'b0, 4'b0011); add(3, 1'b0, 4'b0001);

    rst = 1'b1;
    button = 1'b0;
    button_al = 1'b1;
    model_reset();
    @(negedge clk);
    check("reset_ah", pack0, 4'b0000);
    check("reset_al", pack1, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].bin);
      check($sformatf("vec%0d_ah", i), pack0, vecs[i].exp);
      check($sformatf("vec%0d_al", i), pack1, vecs[i].exp);
    end

    // Press, then a 0,1,0 bounce at the start of the release.
    run_seg(8, 1'b1, np, nr, pp, rp);
    check("s3_press_cnt", np, 1);
    check("s3_press_pos", pp, 6);
    check("s3_tog_after_press", tog0, 1'b0);
    tr = 0;
    run_seg(1, 1'b0, np, nr, pp, rp); tr += nr;
    run_seg(1, 1'b1, np, nr, pp, rp); tr += nr;
    run_seg(9, 1'b0, np, nr, pp, rp); tr += nr;
    check("s3_rel_cnt", tr, 1);
    check("s3_rel_pos", rp, 6);
    check("s3_level", lvl0, 1'b0);
    check("s3_tog_kept", tog0, 1'b0);

    // Two full press/release cycles.
    tp = 0; tr = 0;
    run_seg(10, 1'b1, np, nr, pp, rp); tp += np; tr += nr;
    check("s4_tog1", tog0, 1'b1);
    run_seg(10, 1'b0, np, nr, pp, rp); tp += np; tr += nr;
    run_seg(10, 1'b1, np, nr, pp, rp); tp += np; tr += nr;
    check("s4_tog2", tog0, 1'b0);
    run_seg(10, 1'b0, np, nr, pp, rp); tp += np; tr += nr;
    check("s4_press_cnt", tp, 2);
    check("s4_rel_cnt", tr, 2);

    // Async reset in PRESS_WAIT with cnt=2, button held through reset.
    run_seg(8, 1'b1, np, nr, pp, rp);
    run_seg(8, 1'b0, np, nr, pp, rp);
    run_seg(5, 1'b1, np, nr, pp, rp);
    check("s5_pre_tog", tog0, 1'b1);
    check("s5_pre_level", lvl0, 1'b0);
    async_reset("s5");
    run_seg(10, 1'b1, np, nr, pp, rp);
    check("s5_press_cnt", np, 1);
    check("s5_press_pos", pp, 6);
    check("s5_tog_after", tog0, 1'b1);

    // Async reset while the press strobe is high.
    run_seg(8, 1'b0, np, nr, pp, rp);
    run_seg(7, 1'b1, np, nr, pp, rp);
    check("strobe_pre_reset", prs0, 1'b1);
    async_reset("strobe");

    // Randomized bursts: short bounces mixed with long stable runs.
    last_press = -1;
    while (step_no < 800) begin
      bv  = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(6, 14))
                                        : int'($urandom_range(1, 4));
      for (int i = 0; i < len; i++) begin
        step(bv);
        check("strobe_excl", prs0 & rel0, 1'b0);
        if (prs0) begin
          if (last_press >= 0) check("press_gap", (step_no - last_press) >= 2 * DEB + 2, 1'b1);
          last_press = step_no;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
